// File: rtl/speed_test_pkg.sv
// Shared constants, FSM encoding and the payload mangle rule for the speed_test
// driver/client pair; benches import expected() so both sides agree on one rule.
package speed_test_pkg;

    localparam int HDR_LEN     = 8;
    localparam int MAX_PAYLOAD = 1472;
    localparam int LEN_TAIL    = 9;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        PAY,
        GAP
    } st_t;

    // Client response to payload byte b at packet index idx (index wraps at 256)
    function automatic logic [7:0] expected(input logic [7:0]  b,
                                            input logic [10:0] idx,
                                            input logic        nomangle);
        return b ^ (idx[7:0] & {8{~nomangle}});
    endfunction

    function automatic logic [10:0] clamp_len(input logic [10:0] len);
        if (len == 11'd0)
            return 11'd1;
        if (len > 11'(MAX_PAYLOAD))
            return 11'(MAX_PAYLOAD);
        return len;
    endfunction

endpackage

// File: rtl/speed_test_if.sv
// RTEFI client bus: the driver owns len_c/idata/raw_l/raw_s, the client returns odata.
interface speed_test_if;

    logic [10:0] len_c;
    logic [7:0]  idata;
    logic        raw_l;
    logic        raw_s;
    logic [7:0]  odata;

    modport master (
        output len_c,
        output idata,
        output raw_l,
        output raw_s,
        input  odata
    );

    modport slave (
        input  len_c,
        input  idata,
        input  raw_l,
        input  raw_s,
        output odata
    );

endinterface

// File: rtl/speed_test_check.sv
// Delays each expected payload byte by n_lat cycles, compares it with the client's
// odata and keeps the run's saturating error count and first failing index.
module speed_test_check
    import speed_test_pkg::*;
#(
    parameter int n_lat = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        push,
    input  logic [7:0]  exp,
    input  logic [10:0] idx,
    input  logic [7:0]  odata,
    output logic        mis,
    output logic [15:0] err_count,
    output logic [10:0] first_err
);

    logic        vld_p [n_lat];
    logic [7:0]  exp_p [n_lat];
    logic [10:0] idx_p [n_lat];

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage boundary: only the valid flags are flushed, the data rides along
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < n_lat; k++)
                vld_p[k] <= 1'b0;
        end else begin
            vld_p[0] <= push;
            for (int k = 1; k < n_lat; k++)
                vld_p[k] <= vld_p[k-1];
        end
    end

    always_ff @(posedge clk) begin
        exp_p[0] <= exp;
        idx_p[0] <= idx;
        for (int k = 1; k < n_lat; k++) begin
            exp_p[k] <= exp_p[k-1];
            idx_p[k] <= idx_p[k-1];
        end
    end

    assign mis = vld_p[n_lat-1] && (odata != exp_p[n_lat-1]);

    // Output stage: a zero count means this is the run's first mismatch
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            err_count <= 16'd0;
            first_err <= 11'd0;
        end else if (mis) begin
            err_count <= sat_inc(err_count);
            if (err_count == 16'd0)
                first_err <= idx_p[n_lat-1];
        end
    end

endmodule

// File: rtl/speed_test_driver.sv
// RTEFI-side stimulus master: plays header/payload/gap packets into a client and
// checks the returned payload through speed_test_check.
module speed_test_driver
    import speed_test_pkg::*;
#(
    parameter int n_lat = 2,
    parameter int gap   = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [15:0]         n_pkt,
    input  logic [10:0]         pkt_len,
    input  logic [7:0]          seed,
    input  logic                nomangle,
    speed_test_if.master        bus,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [15:0]         err_count,
    output logic [10:0]         first_err
);

    // The gap must also cover the client latency so every byte is checked in-packet
    localparam int          GAP_CYC  = (gap > n_lat) ? gap : n_lat;
    localparam logic [10:0] GAP_LAST = 11'(GAP_CYC - 1);
    localparam logic [10:0] HDR_LAST = 11'(HDR_LEN - 1);
    localparam logic [10:0] HDR_L11  = 11'(HDR_LEN);

    st_t         state, state_nx;
    logic [10:0] cnt, cnt_nx;
    logic [15:0] pkt_left, pkt_left_nx;
    logic [10:0] len_lat, len_lat_nx;
    logic [7:0]  seed_lat, seed_lat_nx;

    logic [10:0] len_c_q, len_c_nx;
    logic [7:0]  idata_q, idata_nx;
    logic        raw_l_q, raw_l_nx;
    logic        raw_s_q, raw_s_nx;
    logic        busy_nx, done_nx, pass_nx;
    logic        accept;
    logic        mis;

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        pkt_left_nx = pkt_left;
        len_lat_nx  = len_lat;
        seed_lat_nx = seed_lat;
        len_c_nx    = 11'd0;
        idata_nx    = 8'd0;
        raw_l_nx    = 1'b0;
        raw_s_nx    = 1'b0;
        busy_nx     = busy;
        done_nx     = 1'b0;
        pass_nx     = pass;
        accept      = 1'b0;

        case (state)
            IDLE: begin
                // done is high on the first IDLE cycle, so a start there is dropped
                if (start && !done) begin
                    accept      = 1'b1;
                    state_nx    = HDR;
                    cnt_nx      = 11'd0;
                    pkt_left_nx = (n_pkt == 16'd0) ? 16'd1 : n_pkt;
                    len_lat_nx  = clamp_len(pkt_len);
                    seed_lat_nx = seed;
                    busy_nx     = 1'b1;
                    pass_nx     = 1'b0;
                    raw_l_nx    = 1'b1;
                    len_c_nx    = clamp_len(pkt_len) + HDR_L11;
                end
            end

            HDR: begin
                raw_l_nx = 1'b1;
                len_c_nx = len_lat + HDR_L11;
                cnt_nx   = cnt + 11'd1;
                if (cnt == HDR_LAST) begin
                    state_nx = PAY;
                    cnt_nx   = 11'd0;
                    raw_s_nx = 1'b1;
                    idata_nx = seed_lat;
                end
            end

            PAY: begin
                if (cnt == len_lat - 11'd1) begin
                    state_nx = GAP;
                    cnt_nx   = 11'd0;
                end else begin
                    cnt_nx   = cnt + 11'd1;
                    raw_l_nx = 1'b1;
                    raw_s_nx = 1'b1;
                    idata_nx = seed_lat + cnt_nx[7:0];
                    len_c_nx = len_lat + HDR_L11 - cnt_nx;
                end
            end

            GAP: begin
                cnt_nx = cnt + 11'd1;
                if (cnt == GAP_LAST) begin
                    cnt_nx      = 11'd0;
                    pkt_left_nx = pkt_left - 16'd1;
                    if (pkt_left == 16'd1) begin
                        state_nx = IDLE;
                        busy_nx  = 1'b0;
                        done_nx  = 1'b1;
                        // Include a mismatch being flagged on this very cycle
                        pass_nx  = (err_count == 16'd0) && !mis;
                    end else begin
                        state_nx = HDR;
                        raw_l_nx = 1'b1;
                        len_c_nx = len_lat + HDR_L11;
                    end
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= 11'd0;
            pkt_left <= 16'd0;
            len_c_q  <= 11'd0;
            idata_q  <= 8'd0;
            raw_l_q  <= 1'b0;
            raw_s_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            pkt_left <= pkt_left_nx;
            len_c_q  <= len_c_nx;
            idata_q  <= idata_nx;
            raw_l_q  <= raw_l_nx;
            raw_s_q  <= raw_s_nx;
            busy     <= busy_nx;
            done     <= done_nx;
            pass     <= pass_nx;
        end
    end

    // Run configuration is only meaningful once a start has been accepted
    always_ff @(posedge clk) begin
        len_lat  <= len_lat_nx;
        seed_lat <= seed_lat_nx;
    end

    assign bus.len_c = len_c_q;
    assign bus.idata = idata_q;
    assign bus.raw_l = raw_l_q;
    assign bus.raw_s = raw_s_q;

    speed_test_check #(
        .n_lat (n_lat)
    ) u_check (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (accept),
        .push      (raw_s_q),
        .exp       (expected(idata_q, cnt, nomangle)),
        .idx       (cnt),
        .odata     (bus.odata),
        .mis       (mis),
        .err_count (err_count),
        .first_err (first_err)
    );

endmodule

// File: tb/tb_speed_test_driver.sv
// Bench for speed_test_driver: a behavioural client closes the loop, a table of
// directed runs plus random runs are checked against a packet-level model.
module tb_speed_test_driver;
    import speed_test_pkg::*;

    localparam int N_LAT = 3;
    localparam int GAP_P = 2;
    localparam int G     = (GAP_P > N_LAT) ? GAP_P : N_LAT;
    localparam int LIMIT = 20000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] n_pkt = 16'd0;
    logic [10:0] pkt_len = 11'd0;
    logic [7:0]  seed = 8'd0;
    logic        nomangle = 1'b0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [10:0] first_err;

    speed_test_if bus ();

    speed_test_driver #(.n_lat(N_LAT), .gap(GAP_P)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .n_pkt     (n_pkt),
        .pkt_len   (pkt_len),
        .seed      (seed),
        .nomangle  (nomangle),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count),
        .first_err (first_err)
    );

    always #5 clk = ~clk;

    // Client model: mode 0 mangles, 1 echoes, 2 is stuck at zero; optional single corrupted byte
    int         cmode = 0;
    int         corrupt_at = -1;
    logic [7:0] dl [N_LAT];
    logic [7:0] cidx = 8'd0;
    int         gcnt = 0;

    always @(posedge clk) begin
        logic [7:0] r;
        case (cmode)
            0:       r = bus.idata ^ cidx;
            1:       r = bus.idata;
            default: r = 8'd0;
        endcase
        if (bus.raw_s && gcnt == corrupt_at)
            r = r ^ 8'h5A;
        dl[0] <= r;
        for (int k = 1; k < N_LAT; k++)
            dl[k] <= dl[k-1];
        cidx <= bus.raw_s ? cidx + 8'd1 : 8'd0;
        if (!busy)
            gcnt <= 0;
        else if (bus.raw_s)
            gcnt <= gcnt + 1;
    end

    assign bus.odata = dl[N_LAT-1];

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endtask

    function automatic int eff_n(input int n);
        return (n == 0) ? 1 : n;
    endfunction

    function automatic int eff_l(input int l);
        if (l == 0) return 1;
        if (l > MAX_PAYLOAD) return MAX_PAYLOAD;
        return l;
    endfunction

    // Expected per-cycle {busy, raw_l, raw_s, len_c, idata} from first header cycle to last gap cycle
    logic [21:0] exp_q [$];

    function automatic void build_trace(input int n, input int l, input int s);
        int nn = eff_n(n);
        int ll = eff_l(l);
        exp_q.delete();
        for (int p = 0; p < nn; p++) begin
            for (int h = 0; h < HDR_LEN; h++)
                exp_q.push_back({1'b1, 1'b1, 1'b0, 11'(ll + 8), 8'd0});
            for (int i = 0; i < ll; i++)
                exp_q.push_back({1'b1, 1'b1, 1'b1, 11'(ll + 8 - i), 8'((s + i) % 256)});
            for (int g = 0; g < G; g++)
                exp_q.push_back({1'b1, 1'b0, 1'b0, 11'd0, 8'd0});
        end
    endfunction

    function automatic void model_errs(input int n, input int l, input int s, input bit nm,
                                       input int cm, input int ca,
                                       output int err, output int first);
        int g = 0;
        err = 0;
        first = 0;
        for (int p = 0; p < eff_n(n); p++)
            for (int i = 0; i < eff_l(l); i++) begin
                int drv = (s + i) % 256;
                int want = nm ? drv : (drv ^ (i % 256));
                int got = (cm == 0) ? (drv ^ (i % 256)) : (cm == 1) ? drv : 0;
                if (g == ca) got = got ^ 'h5A;
                if (got != want) begin
                    if (err == 0) first = i;
                    err++;
                end
                g++;
            end
    endfunction

    task automatic do_run(input int n, input int l, input int s, input bit nm, input int cm,
                          input int ca, input int poke, input bit pdone,
                          output int o_err, output int o_first, output int o_pass);
        logic [21:0] obs [$];
        bit got_done = 1'b0;
        int bad = -1;
        cmode = cm;
        corrupt_at = ca;
        @(negedge clk);
        start = 1'b1; n_pkt = 16'(n); pkt_len = 11'(l); seed = 8'(s); nomangle = nm;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < LIMIT; c++) begin
            if (done) begin
                got_done = 1'b1;
                break;
            end
            obs.push_back({busy, bus.raw_l, bus.raw_s, bus.len_c, bus.idata});
            if (c == poke) begin
                start = 1'b1;
                pkt_len = 11'd7;
            end
            @(negedge clk);
            start = 1'b0;
        end
        check("done_seen", int'(got_done), 1);
        build_trace(n, l, s);
        check("trace_len", obs.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs.size(); i++)
            if (obs[i] !== exp_q[i]) begin
                bad = i;
                break;
            end
        n_checks++;
        if (bad < 0)
            n_pass++;
        else
            $display("FAIL trace cycle %0d: got %h, expected %h", bad, obs[bad], exp_q[bad]);
        o_err = int'(err_count);
        o_first = int'(first_err);
        o_pass = int'(pass);
        if (pdone) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", int'(done), 0);
        if (pdone) check("start_on_done_ignored", int'(busy), 0);
    endtask

    typedef struct {
        int n; int l; int s; bit nm; int cm; int ca; int poke; bit pdone;
        int e_err; int e_first; bit e_pass;
    } vec_t;

    initial begin
        vec_t vt [8];
        int r_err, r_first, r_pass, m_err, m_first, seen;

        vt[0] = '{1, 4,    'h10, 1'b0, 0, -1, -1, 1'b0, 0,    0, 1'b1};
        vt[1] = '{1, 4,    'h10, 1'b1, 1, -1, -1, 1'b0, 0,    0, 1'b1};
        vt[2] = '{1, 4,    'h10, 1'b0, 1, -1, -1, 1'b0, 3,    1, 1'b0};
        vt[3] = '{1, 300,  'hFF, 1'b0, 0, -1, -1, 1'b0, 0,    0, 1'b1};
        vt[4] = '{3, 1,    'h5A, 1'b0, 0, -1,  5, 1'b1, 0,    0, 1'b1};
        vt[5] = '{1, 2000, 'h01, 1'b1, 2, -1, -1, 1'b0, 1467, 0, 1'b0};
        vt[6] = '{1, 4,    'h10, 1'b0, 0,  3, -1, 1'b0, 1,    3, 1'b0};
        vt[7] = '{0, 0,    'h33, 1'b1, 1, -1, -1, 1'b0, 0,    0, 1'b1};

        repeat (3) @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_raw_l", int'(bus.raw_l), 0);
        check("rst_len_c", int'(bus.len_c), 0);
        check("rst_err_count", int'(err_count), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 8; v++) begin
            do_run(vt[v].n, vt[v].l, vt[v].s, vt[v].nm, vt[v].cm, vt[v].ca, vt[v].poke,
                   vt[v].pdone, r_err, r_first, r_pass);
            check($sformatf("vec%0d_err_count", v), r_err, vt[v].e_err);
            check($sformatf("vec%0d_first_err", v), r_first, vt[v].e_first);
            check($sformatf("vec%0d_pass", v), r_pass, int'(vt[v].e_pass));
        end

        // Reset in the middle of a payload, then a clean run
        cmode = 1;
        corrupt_at = -1;
        @(negedge clk);
        start = 1'b1; n_pkt = 16'd2; pkt_len = 11'd40; seed = 8'd3; nomangle = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_pay_raw_s", int'(bus.raw_s), 1);
        check("mid_pay_err_nonzero", int'(err_count != 16'd0), 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_outputs", int'({busy, done, pass, bus.raw_l, bus.raw_s, bus.len_c,
                                        bus.idata, err_count, first_err}), 0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        check("no_done_after_reset", seen, 0);
        do_run(1, 5, 'h20, 1'b0, 0, -1, -1, 1'b0, r_err, r_first, r_pass);
        check("post_rst_err_count", r_err, 0);
        check("post_rst_pass", r_pass, 1);

        for (int t = 0; t < 10; t++) begin
            int n = $urandom_range(1, 3);
            int l = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 300) : $urandom_range(0, 20);
            int s = $urandom_range(0, 255);
            bit nm = 1'($urandom_range(0, 1));
            int cm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2) : (nm ? 1 : 0);
            int total = eff_n(n) * eff_l(l);
            int ca = ($urandom_range(0, 1) == 1) ? $urandom_range(0, total - 1) : -1;
            model_errs(n, l, s, nm, cm, ca, m_err, m_first);
            do_run(n, l, s, nm, cm, ca, -1, 1'b0, r_err, r_first, r_pass);
            check($sformatf("rnd%0d_err_count", t), r_err, m_err);
            check($sformatf("rnd%0d_first_err", t), r_first, m_first);
            check($sformatf("rnd%0d_pass", t), r_pass, int'(m_err == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/speed_test_driver.md
Name: speed_test_driver

Overview:
- Stimulus master and checker for the RTEFI client interface; it plays the RTEFI side opposite a speed_test client.
- Generates UDP-like packets (header phase, then payload phase) on len_c/idata/raw_l/raw_s.
- Takes the client's odata back in and checks every payload byte against the expected XOR-with-index mangling.
- Used in self-test builds and benches to exercise clients without a live Ethernet link.

Parameters:
- n_lat, 2, client latency in cycles from idata to odata (minimum 1); must match the client under test.
- gap, 4, idle cycles between packets (minimum 1).

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; begins a run; ignored while busy
- n_pkt  in  16  packets per run, sampled at start; 0 treated as 1
- pkt_len  in  11  payload bytes per packet, sampled at start; 0 becomes 1, values >1472 become 1472
- seed  in  8  first payload byte value, sampled at start
- nomangle  in  1  expected client mode; 1 means expect a pure echo
- odata  in  8  client output data
- len_c  out  11  remaining-length count presented to the client
- idata  out  8  data presented to the client
- raw_l  out  1  packet active (header and payload)
- raw_s  out  1  payload active
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- pass  out  1  result of the last run; valid from done until the next start
- err_count  out  16  mismatching bytes in the current run; saturates at 0xFFFF
- first_err  out  11  payload index of the first mismatch in the run

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All outputs go to 0, the FSM goes to IDLE and the check pipeline is flushed.
  - Reset mid-packet aborts the run with no done pulse.
- FSM states: IDLE, HDR, PAY, GAP.
  - IDLE: on start, latch n_pkt, pkt_len and seed, then go to HDR. busy=1 from the cycle after start.
  - HDR: 8 cycles. raw_l=1, raw_s=0, idata=0, len_c=pkt_len+8 held constant. Then go to PAY.
  - PAY: pkt_len cycles. raw_l=1, raw_s=1. Byte i (from 0) has idata=(seed+i) mod 256 and len_c=pkt_len+8-i, so the last byte has len_c=9. Then go to GAP.
  - GAP: raw_l=raw_s=0, len_c=0, idata=0, for max(gap, n_lat) cycles so the check pipeline drains. Then go to HDR if packets remain, otherwise to IDLE, pulse done and drop busy in the same cycle.
- Outputs are registered, and all four interface signals change on the same edge.
- Check pipeline:
  - Valid flag plus expected byte, depth n_lat.
  - Entry is pushed when raw_s=1.
  - Expected byte = idata ^ (i[7:0] & {8{~nomangle}}), where i is the payload index within the current packet.
  - The index restarts at 0 for each packet and wraps modulo 256 inside long packets.
  - When the pipeline output is valid, compare against odata n_lat cycles after the byte was driven.
  - On mismatch: increment err_count (saturating). If it was the first mismatch of the run, capture i into first_err.
- Run accounting:
  - err_count and first_err clear on an accepted start.
  - pass = (err_count==0), registered on the done cycle.
- Start handling:
  - start during busy is ignored and does not restart.
  - start in the same cycle as the done pulse is ignored; the next cycle accepts it.
- Simultaneous events: a mismatch on the final drained byte is counted before done and pass are produced.
- Width rules:
  - len_c and indices are 11-bit.
  - The packet counter is 16-bit and counts down to 0.
  - seed+i wraps at 8 bits.

Decomposition:
- Shared package speed_test_pkg holds:
  - HDR_LEN=8
  - MAX_PAYLOAD=1472
  - LEN_TAIL=9 (len_c on the last payload byte)
  - FSM state encoding
  - the mangle function expected(byte, index, nomangle), shared with benches
- Natural sub-module: speed_test_check. It owns the n_lat-deep valid/expected/index pipeline and the err_count/first_err logic. Its inputs are clk, rst_n, clear, push, exp, idx, odata.

Test Plan:
- pkt_len=4, seed=0x10, n_pkt=1, nomangle=0, paired with a speed_test client (n_lat=2):
  - header is 8 cycles with len_c=12
  - payload idata is 10,11,12,13 with len_c 12,11,10,9
  - odata is 10,10,10,10
  - done with pass=1, err_count=0
- Same run with nomangle=1 on both sides -> odata equals idata, pass=1. Driver nomangle=0 against a client with nomangle=1 -> err_count=3, first_err=1 (index 0 matches).
- pkt_len=300, seed=0xFF -> idata wraps 0xFF→0x00, the mangle index wraps at byte 256, pass=1, last len_c=9.
- n_pkt=3, pkt_len=1, gap=4 -> three 9-cycle packets, each followed by a gap of max(gap, n_lat) cycles, one done pulse, busy high throughout. A start pulse mid-run changes nothing.
- A bench model with odata stuck at 0 and pkt_len=2000 -> pkt_len clamped to 1472, err_count equals the count of nonzero expected bytes, pass=0.
- rst_n low during PAY for 1 cycle -> all outputs 0 the next cycle, no done pulse. A fresh start then runs cleanly with err_count starting from 0.
